// File: rtl/lcd_seq_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_seq_ctrl
//
// Sequencer for the lcd_write_cmd_data I2C byte writer, which drives an LCD1602
// through its PCF8574 backpack.
//
// After reset the sequencer does the following, in order:
//   1. It waits out LCD power-up.
//   2. It issues the 4-bit-mode init command list.
//   3. It redraws both display lines from a 32-byte character buffer.
// After that the host edits characters through a write port and asks for
// redraws with a one-cycle refresh pulse.
//
// Ports:
//   clk_i           system clock
//   rst_ni          asynchronous active-low reset
//   buf_we_i        character buffer write strobe
//   buf_addr_i      buffer index (0-15 line 1, 16-31 line 2)
//   buf_wdata_i     ASCII character to store
//   refresh_i       single-cycle full-screen redraw request
//   init_done_o     high once the init sequence has completed
//   busy_o          high while a byte transfer or timed wait is in progress
//   err_o           sticky wr_done timeout flag
//   wr_ena_o        enable to the writer
//   wr_data_o       byte to the writer
//   wr_cmd_data_o   0 = command, 1 = data
//   wr_done_i       single-cycle completion pulse from the writer
// -----------------------------------------------------------------------------
module lcd_seq_ctrl #(
  parameter int unsigned PWRUP_CYCLES = 1_500_000,
  parameter int unsigned CLR_CYCLES   = 200_000,
  parameter int unsigned DONE_TIMEOUT = 2_000_000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       buf_we_i,
  input  logic [4:0] buf_addr_i,
  input  logic [7:0] buf_wdata_i,
  input  logic       refresh_i,
  output logic       init_done_o,
  output logic       busy_o,
  output logic       err_o,
  output logic       wr_ena_o,
  output logic [7:0] wr_data_o,
  output logic       wr_cmd_data_o,
  input  logic       wr_done_i
);

  localparam int CNT_W = 21;

  // Counters compare against "last cycle" values, so a wait of N cycles
  // spends exactly N clocks in the waiting state.
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] DONE_LAST  = CNT_W'(DONE_TIMEOUT - 1);

  localparam logic [5:0] INIT_LAST    = 6'd5;
  localparam logic [5:0] REFRESH_LAST = 6'd33;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT_ISSUE,
    ST_INIT_WAIT,
    ST_CLR_WAIT,
    ST_REF_ISSUE,
    ST_REF_WAIT,
    ST_IDLE
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] waitCnt_q;
  logic [CNT_W-1:0] waitCnt_d;
  logic [5:0]       xferIdx_q;
  logic             pending_q;
  logic             wrEna_q;
  logic [7:0]       wrData_q;
  logic             wrCmdData_q;
  logic             initDone_q;
  logic             busy_q;
  logic             err_q;
  logic [7:0]       charBuf_q [32];

  logic [7:0]       initCmd;
  logic [7:0]       refByte;
  logic             refIsData;
  logic [4:0]       refBufIdx;

  assign wr_ena_o      = wrEna_q;
  assign wr_data_o     = wrData_q;
  assign wr_cmd_data_o = wrCmdData_q;
  assign init_done_o   = initDone_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;

  // Saturating increment shared by every timed wait.
  assign waitCnt_d = (waitCnt_q == '1) ? waitCnt_q : waitCnt_q + CNT_W'(1);

  // Init command list for HD44780 4-bit mode: wake-up pair, function set,
  // display on, entry mode, clear.
  always_comb begin
    initCmd = 8'h01;
    case (xferIdx_q)
      6'd0:    initCmd = 8'h33;
      6'd1:    initCmd = 8'h32;
      6'd2:    initCmd = 8'h28;
      6'd3:    initCmd = 8'h0C;
      6'd4:    initCmd = 8'h06;
      default: initCmd = 8'h01;
    endcase
  end

  // Maps a refresh transfer index to its byte.
  //   Index 0 is the line-1 cursor command.
  //   Indices 1-16 are line-1 characters.
  //   Index 17 is the line-2 cursor command.
  //   Indices 18-33 are line-2 characters.
  always_comb begin
    refBufIdx = 5'd0;
    refByte   = 8'h80;
    refIsData = 1'b0;
    if (xferIdx_q == 6'd0) begin
      refByte = 8'h80;
    end else if (xferIdx_q <= 6'd16) begin
      refBufIdx = 5'(xferIdx_q - 6'd1);
      refByte   = charBuf_q[refBufIdx];
      refIsData = 1'b1;
    end else if (xferIdx_q == 6'd17) begin
      refByte = 8'hC0;
    end else begin
      refBufIdx = 5'(xferIdx_q - 6'd2);
      refByte   = charBuf_q[refBufIdx];
      refIsData = 1'b1;
    end
  end

  // Character buffer. Host writes land in any state. The sequencer copies a
  // byte into wr_data on the issue edge, so a write in that same cycle is
  // only seen by the next refresh.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) begin
        charBuf_q[i] <= 8'h20;
      end
    end else if (buf_we_i) begin
      charBuf_q[buf_addr_i] <= buf_wdata_i;
    end
  end

  // Main sequencer.
  // Each ISSUE state raises wr_ena with stable data. Its WAIT state holds the
  // data until wr_done arrives, then drops wr_ena. Going back through ISSUE
  // therefore guarantees at least one low cycle between bytes.
  // A missing wr_done aborts the sequence:
  //   - before init has completed, the sequencer restarts power-up;
  //   - afterwards, it falls back to IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_PWRUP;
      waitCnt_q   <= '0;
      xferIdx_q   <= '0;
      pending_q   <= 1'b0;
      wrEna_q     <= 1'b0;
      wrData_q    <= 8'h00;
      wrCmdData_q <= 1'b0;
      initDone_q  <= 1'b0;
      busy_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      // Requests outside IDLE collapse into one pending redraw.
      if (refresh_i && (state_q != ST_IDLE)) begin
        pending_q <= 1'b1;
      end

      case (state_q)
        ST_PWRUP: begin
          if (waitCnt_q >= PWRUP_LAST) begin
            waitCnt_q <= '0;
            xferIdx_q <= '0;
            state_q   <= ST_INIT_ISSUE;
          end else begin
            waitCnt_q <= waitCnt_d;
          end
        end

        ST_INIT_ISSUE: begin
          wrEna_q     <= 1'b1;
          wrData_q    <= initCmd;
          wrCmdData_q <= 1'b0;
          waitCnt_q   <= '0;
          state_q     <= ST_INIT_WAIT;
        end

        ST_INIT_WAIT: begin
          if (wr_done_i) begin
            wrEna_q <= 1'b0;
            if (xferIdx_q == INIT_LAST) begin
              waitCnt_q <= '0;
              state_q   <= ST_CLR_WAIT;
            end else begin
              xferIdx_q <= xferIdx_q + 6'd1;
              state_q   <= ST_INIT_ISSUE;
            end
          end else if (waitCnt_q >= DONE_LAST) begin
            err_q     <= 1'b1;
            wrEna_q   <= 1'b0;
            waitCnt_q <= '0;
            state_q   <= ST_PWRUP;
          end else begin
            waitCnt_q <= waitCnt_d;
          end
        end

        // The pending flag is cleared here because this automatic first
        // redraw already covers any request made before init finished.
        ST_CLR_WAIT: begin
          if (waitCnt_q >= CLR_LAST) begin
            initDone_q <= 1'b1;
            pending_q  <= 1'b0;
            xferIdx_q  <= '0;
            state_q    <= ST_REF_ISSUE;
          end else begin
            waitCnt_q <= waitCnt_d;
          end
        end

        ST_REF_ISSUE: begin
          wrEna_q     <= 1'b1;
          wrData_q    <= refByte;
          wrCmdData_q <= refIsData;
          waitCnt_q   <= '0;
          state_q     <= ST_REF_WAIT;
        end

        ST_REF_WAIT: begin
          if (wr_done_i) begin
            wrEna_q <= 1'b0;
            if (xferIdx_q == REFRESH_LAST) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              xferIdx_q <= xferIdx_q + 6'd1;
              state_q   <= ST_REF_ISSUE;
            end
          end else if (waitCnt_q >= DONE_LAST) begin
            err_q     <= 1'b1;
            wrEna_q   <= 1'b0;
            waitCnt_q <= '0;
            if (initDone_q) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_PWRUP;
            end
          end else begin
            waitCnt_q <= waitCnt_d;
          end
        end

        ST_IDLE: begin
          if (pending_q || refresh_i) begin
            pending_q <= 1'b0;
            xferIdx_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_REF_ISSUE;
          end
        end

        default: begin
          wrEna_q <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= ST_PWRUP;
        end
      endcase
    end
  end

endmodule
